// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Front-end fetch controller for the dual-issue core. Issues
//             instruction-memory requests for pairs of instructions, buffers
//             the returned pairs in an 8-entry queue and presents the two
//             oldest entries to decode. Handles decode stall, flush/redirect
//             and an upper fetch-address limit.
//  Ports    : clk, reset (async, active-low)
//             stall_if, flush_if, redirect_pc      - decode-side control
//             imem_req_valid/ready/addr            - memory request channel
//             imem_resp_valid/instr1/instr2        - memory response channel
//             instr1/pc1/ins_valid1                - queue head
//             instr2/pc2/ins_valid2                - queue head + 1
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_LIMIT = 32'h250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        flush_if,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_instr1,
    input  logic [31:0] imem_resp_instr2,
    output logic [31:0] instr1,
    output logic [31:0] pc1,
    output logic        ins_valid1,
    output logic [31:0] instr2,
    output logic [31:0] pc2,
    output logic        ins_valid2
);

    // Request is only launched while at least two slots are free, so the
    // pair that comes back always fits regardless of pops in between.
    localparam logic [3:0] c_max_req_count = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [2:0]  r_head;
    logic [2:0]  r_tail;
    logic [3:0]  r_count;

    logic [31:0] r_q_instr [0:7];
    logic [31:0] r_q_pc    [0:7];

    logic        w_req_valid;
    logic        w_handshake;
    logic [31:0] w_pc_plus4;
    logic        w_resp_take;
    logic        w_push1;
    logic        w_push2;
    logic [1:0]  w_push_n;
    logic [1:0]  w_pop_n;
    logic [2:0]  w_slot2;
    logic [2:0]  w_head1;
    logic        w_flush_drain;

    assign w_req_valid = (r_state == S_RUN) && (r_count <= c_max_req_count)
                         && (r_fetch_pc <= PC_LIMIT);
    assign w_handshake = w_req_valid && imem_req_ready;
    assign w_pc_plus4  = r_fetch_pc + 32'd4;

    // A response coinciding with a flush belongs to the old stream: drop it.
    assign w_resp_take = (r_state == S_WAIT) && imem_resp_valid && !flush_if;
    assign w_push1     = w_resp_take && (r_fetch_pc <= PC_LIMIT);
    assign w_push2     = w_resp_take && (w_pc_plus4 <= PC_LIMIT);
    assign w_push_n    = {1'b0, w_push1} + {1'b0, w_push2};
    assign w_slot2     = w_push1 ? (r_tail + 3'd1) : r_tail;
    assign w_head1     = r_head + 3'd1;

    always_comb begin
        w_pop_n = 2'd0;
        if (!stall_if && !flush_if) begin
            w_pop_n = (r_count >= 4'd2) ? 2'd2 : r_count[1:0];
        end
    end

    // After a flush edge a request is still in flight if we were waiting and
    // no response came, or a new request was accepted in the flush cycle.
    assign w_flush_drain = ((r_state == S_WAIT)  && !imem_resp_valid) ||
                           ((r_state == S_DRAIN) && !imem_resp_valid) ||
                           w_handshake;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_head     <= 3'd0;
            r_tail     <= 3'd0;
            r_count    <= 4'd0;
        end else if (flush_if) begin
            r_head     <= 3'd0;
            r_tail     <= 3'd0;
            r_count    <= 4'd0;
            r_fetch_pc <= redirect_pc;
            r_state    <= w_flush_drain ? S_DRAIN : S_RUN;
        end else begin
            r_head  <= r_head + {1'b0, w_pop_n};
            r_tail  <= r_tail + {1'b0, w_push_n};
            r_count <= r_count + {2'b00, w_push_n} - {2'b00, w_pop_n};
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_handshake) begin
                        r_state <= S_WAIT;
                    end else if (r_fetch_pc > PC_LIMIT) begin
                        r_state <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        r_fetch_pc <= r_fetch_pc + 32'd8;
                        r_state    <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        r_state <= S_RUN;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Queue storage needs no reset: every read is qualified by the count.
    always_ff @(posedge clk) begin
        if (w_push1) begin
            r_q_instr[r_tail] <= imem_resp_instr1;
            r_q_pc[r_tail]    <= r_fetch_pc;
        end
        if (w_push2) begin
            r_q_instr[w_slot2] <= imem_resp_instr2;
            r_q_pc[w_slot2]    <= w_pc_plus4;
        end
    end

    // All outputs decode registered state only, so they are zero in reset.
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = w_req_valid ? r_fetch_pc : 32'd0;

    assign ins_valid1 = (r_count >= 4'd1);
    assign ins_valid2 = (r_count >= 4'd2);
    assign instr1     = ins_valid1 ? r_q_instr[r_head]  : 32'd0;
    assign pc1        = ins_valid1 ? r_q_pc[r_head]     : 32'd0;
    assign instr2     = ins_valid2 ? r_q_instr[w_head1] : 32'd0;
    assign pc2        = ins_valid2 ? r_q_pc[w_head1]    : 32'd0;

endmodule
`default_nettype wire
